uart_tx_stream: RTL

UART_TX_STREAM -- requirements
Module: uart_tx_stream

---
 rtl/uart_tx_stream.sv | 129 ++++++++++++
 1 files changed

// File: rtl/uart_tx_stream.sv
// uart_tx_stream: byte-stream UART transmitter (8N1 / 8N2) with clear-to-send gating.
// A byte is acknowledged with a one-cycle 'next' pulse at the moment it is captured.
// Every output comes from a flop, so txd never glitches.
module uart_tx_stream #(
  parameter int CLK_DIV   = 104,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_valid,
  input  logic [7:0] data,
  output logic       next,
  input  logic       cts,
  output logic       txd,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state;
  logic [7:0]       shift_reg;
  logic [2:0]       bit_idx;
  logic [CNT_W-1:0] bit_cnt;
  logic             stop_idx;
  logic             can_start;
  logic             bit_last;

  // A new frame may begin only when upstream offers a byte and the receiver is ready;
  // bit_last marks the final clk cycle of the current bit period.
  always_comb begin
    can_start = data_valid && cts;
    bit_last  = (bit_cnt == CNT_LAST);
  end

  // Frame sequencer: start bit, eight data bits LSB first, stop bit(s). The last stop
  // cycle doubles as the first idle decision so back-to-back frames have no gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      txd       <= 1'b1;
      next      <= 1'b0;
      busy      <= 1'b0;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      shift_reg <= '0;
    end else begin
      next <= 1'b0;
      case (state)
        IDLE: begin
          if (can_start) begin
            shift_reg <= data;
            next      <= 1'b1;
            txd       <= 1'b0;
            busy      <= 1'b1;
            bit_cnt   <= '0;
            state     <= START;
          end else begin
            txd  <= 1'b1;
            busy <= 1'b0;
          end
        end
        START: begin
          if (bit_last) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            txd     <= shift_reg[0];
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_last) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              txd      <= 1'b1;
              stop_idx <= 1'b0;
              state    <= STOP;
            end else begin
              shift_reg <= {1'b0, shift_reg[7:1]};
              txd       <= shift_reg[1];
              bit_idx   <= bit_idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_last) begin
            bit_cnt <= '0;
            if (stop_idx == STOP_LAST) begin
              if (can_start) begin
                shift_reg <= data;
                next      <= 1'b1;
                txd       <= 1'b0;
                busy      <= 1'b1;
                state     <= START;
              end else begin
                txd   <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: begin
          txd   <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
